// File: rtl/exception_spr_unit_if.sv
// Bus bundle for exception_spr_unit: cause/context inputs, SPR access port and register views.
// The slave side is the SPR unit itself; the master side drives causes and SPR accesses.
interface exception_spr_unit_if;
  logic [22:0] ca;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] ea;
  logic        rpt;
  logic        eret;
  logic        spr_we;
  logic [2:0]  spr_addr;
  logic [31:0] spr_wdata;
  logic [31:0] spr_rdata;
  logic [31:0] sr_out;
  logic [31:0] esr_out;
  logic [31:0] eca_out;
  logic [31:0] epc_out;
  logic [31:0] edata_out;
  logic [31:0] pto;
  logic [31:0] ptl;
  logic        mode_out;
  logic        jisr;
  logic [4:0]  il;

  modport master (
    output ca, pc, next_pc, ea, rpt, eret, spr_we, spr_addr, spr_wdata,
    input  spr_rdata, sr_out, esr_out, eca_out, epc_out, edata_out, pto, ptl,
           mode_out, jisr, il
  );

  modport slave (
    input  ca, pc, next_pc, ea, rpt, eret, spr_we, spr_addr, spr_wdata,
    output spr_rdata, sr_out, esr_out, eca_out, epc_out, edata_out, pto, ptl,
           mode_out, jisr, il
  );
endinterface

// File: rtl/exception_spr_unit.sv
// Interrupt masking/prioritisation plus the special-purpose register file.
// Saves machine context on jisr, restores it on eret, and serves move-to/from-SPR accesses.
module exception_spr_unit (
  input logic                  clk,
  input logic                  rst_n,
  exception_spr_unit_if.slave  bus
);

  logic [31:0] r_sr, r_esr, r_eca, r_epc, r_edata, r_pto, r_ptl;
  logic        r_mode, r_emode;

  logic [31:0] w_sr_d, w_esr_d, w_eca_d, w_epc_d, w_edata_d, w_pto_d, w_ptl_d;
  logic        w_mode_d, w_emode_d;

  logic [22:0] w_mca;
  logic        w_jisr;
  logic [4:0]  w_il;

  // Causes 0..5 are unmaskable; the rest are gated by the matching SR bit.
  assign w_mca  = {bus.ca[22:6] & r_sr[22:6], bus.ca[5:0]};
  assign w_jisr = |w_mca;

  always_comb begin
    w_il = 5'd0;
    for (int i = 22; i >= 0; i--) begin
      if (w_mca[i]) w_il = 5'(i);
    end
  end

  always_comb begin
    w_sr_d    = r_sr;
    w_esr_d   = r_esr;
    w_eca_d   = r_eca;
    w_epc_d   = r_epc;
    w_edata_d = r_edata;
    w_pto_d   = r_pto;
    w_ptl_d   = r_ptl;
    w_mode_d  = r_mode;
    w_emode_d = r_emode;
    if (w_jisr) begin
      w_esr_d   = r_sr;
      w_sr_d    = 32'd0;
      w_eca_d   = {9'd0, w_mca};
      w_epc_d   = bus.rpt ? bus.pc : bus.next_pc;
      w_edata_d = bus.ea;
      w_emode_d = r_mode;
      w_mode_d  = 1'b0;
    end else if (bus.eret) begin
      w_sr_d   = r_esr;
      w_mode_d = r_emode;
    end else if (bus.spr_we) begin
      unique case (bus.spr_addr)
        3'd0: w_sr_d    = bus.spr_wdata;
        3'd1: w_esr_d   = bus.spr_wdata;
        3'd2: w_eca_d   = bus.spr_wdata;
        3'd3: w_epc_d   = bus.spr_wdata;
        3'd4: w_edata_d = bus.spr_wdata;
        3'd5: w_pto_d   = bus.spr_wdata;
        3'd6: w_ptl_d   = bus.spr_wdata;
        3'd7: begin
          w_mode_d  = bus.spr_wdata[0];
          w_emode_d = bus.spr_wdata[1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr    <= 32'd0;
      r_esr   <= 32'd0;
      r_eca   <= 32'd0;
      r_epc   <= 32'd0;
      r_edata <= 32'd0;
      r_pto   <= 32'd0;
      r_ptl   <= 32'd0;
      r_mode  <= 1'b0;
      r_emode <= 1'b0;
    end else begin
      r_sr    <= w_sr_d;
      r_esr   <= w_esr_d;
      r_eca   <= w_eca_d;
      r_epc   <= w_epc_d;
      r_edata <= w_edata_d;
      r_pto   <= w_pto_d;
      r_ptl   <= w_ptl_d;
      r_mode  <= w_mode_d;
      r_emode <= w_emode_d;
    end
  end

  always_comb begin
    bus.spr_rdata = 32'd0;
    unique case (bus.spr_addr)
      3'd0: bus.spr_rdata = r_sr;
      3'd1: bus.spr_rdata = r_esr;
      3'd2: bus.spr_rdata = r_eca;
      3'd3: bus.spr_rdata = r_epc;
      3'd4: bus.spr_rdata = r_edata;
      3'd5: bus.spr_rdata = r_pto;
      3'd6: bus.spr_rdata = r_ptl;
      3'd7: bus.spr_rdata = {30'd0, r_emode, r_mode};
      default: ;
    endcase
  end

  assign bus.sr_out    = r_sr;
  assign bus.esr_out   = r_esr;
  assign bus.eca_out   = r_eca;
  assign bus.epc_out   = r_epc;
  assign bus.edata_out = r_edata;
  assign bus.pto       = r_pto;
  assign bus.ptl       = r_ptl;
  assign bus.mode_out  = r_mode;
  assign bus.jisr      = w_jisr;
  assign bus.il        = w_il;

endmodule

// File: tb/tb_exception_spr_unit.sv
// Scoreboard bench for exception_spr_unit: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_exception_spr_unit;

  logic clk;
  logic rst_n;
  exception_spr_unit_if bus ();

  exception_spr_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    SelSr, SelEsr, SelEca, SelEpc, SelEdata, SelPto, SelPtl, SelMode, SelJisr, SelIl, SelRdata
  } sel_e;

  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_err;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      SelSr:    return bus.sr_out;
      SelEsr:   return bus.esr_out;
      SelEca:   return bus.eca_out;
      SelEpc:   return bus.epc_out;
      SelEdata: return bus.edata_out;
      SelPto:   return bus.pto;
      SelPtl:   return bus.ptl;
      SelMode:  return {31'd0, bus.mode_out};
      SelJisr:  return {31'd0, bus.jisr};
      SelIl:    return {27'd0, bus.il};
      default:  return bus.spr_rdata;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = q.pop_front();
      act = observe(e.sel);
      n_vec++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got 32'h%08h expected 32'h%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_val(input string name, input sel_e sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spr_write(input logic [2:0] a, input logic [31:0] d);
    bus.spr_we    = 1'b1;
    bus.spr_addr  = a;
    bus.spr_wdata = d;
    step();
    bus.spr_we    = 1'b0;
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.ca        = '0;
    bus.pc        = '0;
    bus.next_pc   = '0;
    bus.ea        = '0;
    bus.rpt       = 1'b0;
    bus.eret      = 1'b0;
    bus.spr_we    = 1'b0;
    bus.spr_addr  = '0;
    bus.spr_wdata = '0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Load some state, then drop reset between edges.
    spr_write(3'd5, 32'h0000_A5A5);
    spr_write(3'd7, 32'h3);
    spr_write(3'd0, 32'h0000_FFC0);
    expect_val("pto_written", SelPto, 32'h0000_A5A5);
    expect_val("mode_written", SelMode, 32'h1);
    expect_val("sr_written", SelSr, 32'h0000_FFC0);
    step();
    rst_n = 1'b0;
    expect_val("rst_sr", SelSr, 32'h0);
    expect_val("rst_pto", SelPto, 32'h0);
    expect_val("rst_mode", SelMode, 32'h0);
    expect_val("rst_jisr", SelJisr, 32'h0);
    bus.spr_addr = 3'd7;
    expect_val("rst_rd7", SelRdata, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Masking: ca[10] blocked until SR bit 10 is set.
    bus.ca        = 23'h000400;
    bus.spr_we    = 1'b1;
    bus.spr_addr  = 3'd0;
    bus.spr_wdata = 32'h0000_0400;
    expect_val("mask_jisr_off", SelJisr, 32'h0);
    step();
    bus.spr_we  = 1'b0;
    bus.rpt     = 1'b0;
    bus.pc      = 32'h100;
    bus.next_pc = 32'h104;
    bus.ea      = 32'h0000_DEAD;
    expect_val("mask_jisr_on", SelJisr, 32'h1);
    expect_val("mask_il", SelIl, 32'd10);
    step();
    bus.ca = '0;
    expect_val("m_eca", SelEca, 32'h400);
    expect_val("m_epc_nextpc", SelEpc, 32'h104);
    expect_val("m_edata", SelEdata, 32'h0000_DEAD);
    expect_val("m_sr_cleared", SelSr, 32'h0);
    expect_val("m_esr", SelEsr, 32'h400);
    expect_val("m_jisr_masked", SelJisr, 32'h0);
    step();

    // Priority of simultaneous causes; repeat-type saves pc.
    bus.ca  = 23'h000024;
    bus.rpt = 1'b1;
    bus.ea  = 32'h0000_CAFE;
    expect_val("pri_il", SelIl, 32'd2);
    expect_val("pri_jisr", SelJisr, 32'h1);
    step();
    bus.ca  = '0;
    bus.rpt = 1'b0;
    expect_val("pri_eca", SelEca, 32'h24);
    expect_val("pri_edata", SelEdata, 32'h0000_CAFE);
    expect_val("pri_epc_pc", SelEpc, 32'h100);
    expect_val("pri_sr", SelSr, 32'h0);
    expect_val("pri_il_idle", SelIl, 32'd0);
    step();

    // Save/restore of SR and mode.
    spr_write(3'd7, 32'h1);
    spr_write(3'd0, 32'h0000_FFC0);
    expect_val("sv_sr_setup", SelSr, 32'h0000_FFC0);
    expect_val("sv_mode_setup", SelMode, 32'h1);
    bus.ca = 23'h000020;
    step();
    bus.ca       = '0;
    bus.spr_addr = 3'd7;
    expect_val("sv_esr", SelEsr, 32'h0000_FFC0);
    expect_val("sv_mode_sys", SelMode, 32'h0);
    expect_val("sv_sr_zero", SelSr, 32'h0);
    expect_val("sv_rd7_emode", SelRdata, 32'h2);
    bus.eret = 1'b1;
    step();
    bus.eret = 1'b0;
    expect_val("eret_sr", SelSr, 32'h0000_FFC0);
    expect_val("eret_mode", SelMode, 32'h1);
    expect_val("eret_rd7", SelRdata, 32'h3);
    step();

    // Conflicts: eret drops a write; jisr overrides eret and drops a write.
    bus.eret      = 1'b1;
    bus.spr_we    = 1'b1;
    bus.spr_addr  = 3'd5;
    bus.spr_wdata = 32'h0000_1234;
    step();
    bus.eret   = 1'b0;
    bus.spr_we = 1'b0;
    expect_val("cf_pto_kept", SelPto, 32'h0);
    expect_val("cf_eret_sr", SelSr, 32'h0000_FFC0);
    bus.ca        = 23'h000002;
    bus.eret      = 1'b1;
    bus.spr_we    = 1'b1;
    bus.spr_addr  = 3'd6;
    bus.spr_wdata = 32'h77;
    expect_val("cf_jisr", SelJisr, 32'h1);
    expect_val("cf_il", SelIl, 32'd1);
    step();
    bus.ca     = '0;
    bus.eret   = 1'b0;
    bus.spr_we = 1'b0;
    expect_val("cf_sr_zero", SelSr, 32'h0);
    expect_val("cf_esr", SelEsr, 32'h0000_FFC0);
    expect_val("cf_eca", SelEca, 32'h2);
    expect_val("cf_ptl_kept", SelPtl, 32'h0);
    expect_val("cf_mode", SelMode, 32'h0);
    step();
    spr_write(3'd6, 32'h77);
    bus.spr_addr = 3'd6;
    expect_val("ptl_written", SelPtl, 32'h77);
    expect_val("ptl_read", SelRdata, 32'h77);

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
